// File: rtl/demux_1_16_9b_bank_pkg.sv
// rtl/demux_1_16_9b_bank_pkg.sv - shared state encodings and sizes for the 16-entry write bank
package demux_1_16_9b_bank_pkg;

    localparam int NUM_ENTRIES = 16;
    localparam int DEF_WIDTH   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CLEAR = 2'd2
    } bank_state_t;

endpackage

// File: rtl/demux_1_16_9b_bank_reg_9b_en.sv
// rtl/demux_1_16_9b_bank_reg_9b_en.sv - one holding register with load enable and async reset value
module reg_9b_en
    import demux_1_16_9b_bank_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux_1_16_9b_bank.sv
// rtl/demux_1_16_9b_bank.sv - steers one input word into one of 16 registers; single, burst and clear writes
module demux_1_16_9b_bank
    import demux_1_16_9b_bank_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             sel3,
    input  logic             sel2,
    input  logic             sel1,
    input  logic             sel0,
    input  logic             wr,
    input  logic             burst_start,
    input  logic             clr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D_OUT,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] H,
    output logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] L,
    output logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] P,
    output logic [15:0]      VLD,
    output logic             ready,
    output logic             done
);

    bank_state_t            state, next_state;
    logic [3:0]             ptr, next_ptr;
    logic [3:0]             cnt, next_cnt;
    logic                   next_done;
    logic                   wr_en;
    logic [3:0]             widx;
    logic [3:0]             sel;
    logic [NUM_ENTRIES-1:0] we;
    logic [WIDTH-1:0]       wdata;
    logic [WIDTH-1:0]       q [NUM_ENTRIES];

    assign sel = {sel3, sel2, sel1, sel0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            cnt   <= next_cnt;
            done  <= next_done;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_cnt   = cnt;
        next_done  = 1'b0;
        wr_en      = 1'b0;
        widx       = ptr;
        case (state)
            ST_IDLE: begin
                if (clr) begin
                    next_ptr   = '0;
                    next_state = ST_CLEAR;
                end else if (burst_start) begin
                    next_ptr   = sel;
                    next_cnt   = '0;
                    next_state = ST_BURST;
                end else if (wr) begin
                    wr_en = 1'b1;
                    widx  = sel;
                end
            end
            ST_BURST: begin
                // clr wins over a same-cycle write and suppresses the burst completion pulse
                if (clr) begin
                    next_ptr   = '0;
                    next_state = ST_CLEAR;
                end else if (wr) begin
                    wr_en    = 1'b1;
                    next_ptr = ptr + 4'd1;
                    next_cnt = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        next_state = ST_IDLE;
                        next_done  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                wr_en    = 1'b1;
                next_ptr = ptr + 4'd1;
                if (ptr == 4'd15) begin
                    next_state = ST_IDLE;
                    next_done  = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign we    = wr_en ? ({{(NUM_ENTRIES-1){1'b0}}, 1'b1} << widx) : '0;
    assign wdata = (state == ST_CLEAR) ? CLR_VAL : D;
    assign ready = (state != ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            VLD <= '0;
        end else if (state == ST_CLEAR) begin
            VLD <= VLD & ~we;
        end else begin
            VLD <= VLD | we;
        end
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        reg_9b_en #(
            .WIDTH   (WIDTH),
            .CLR_VAL (CLR_VAL)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (we[i]),
            .d   (wdata),
            .q   (q[i])
        );
    end

    assign A     = q[0];
    assign B     = q[1];
    assign C     = q[2];
    assign D_OUT = q[3];
    assign E     = q[4];
    assign F     = q[5];
    assign G     = q[6];
    assign H     = q[7];
    assign I     = q[8];
    assign J     = q[9];
    assign K     = q[10];
    assign L     = q[11];
    assign M     = q[12];
    assign N     = q[13];
    assign O     = q[14];
    assign P     = q[15];

endmodule

// File: tb/tb_demux_1_16_9b_bank.sv
// tb/tb_demux_1_16_9b_bank.sv - scoreboard bench for the 16-entry write bank
module tb_demux_1_16_9b_bank;

    typedef struct packed {
        logic [15:0][8:0] e;
        logic [15:0]      v;
        logic             rdy;
        logic             dn;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] din = '0;
    logic       sel3 = 1'b0, sel2 = 1'b0, sel1 = 1'b0, sel0 = 1'b0;
    logic       wr = 1'b0, burst_start = 1'b0, clr = 1'b0;
    logic [8:0] a, b, c, d_out, e, f, g, h, i_o, j, k, l, m, n, o, p;
    logic [15:0] vld;
    logic       ready, done;

    int errors = 0;
    int checks = 0;

    demux_1_16_9b_bank dut (
        .clk(clk), .rst(rst), .D(din),
        .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0),
        .wr(wr), .burst_start(burst_start), .clr(clr),
        .A(a), .B(b), .C(c), .D_OUT(d_out), .E(e), .F(f), .G(g), .H(h),
        .I(i_o), .J(j), .K(k), .L(l), .M(m), .N(n), .O(o), .P(p),
        .VLD(vld), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    logic [8:0] act [16];
    assign act[0] = a;   assign act[1] = b;   assign act[2] = c;   assign act[3] = d_out;
    assign act[4] = e;   assign act[5] = f;   assign act[6] = g;   assign act[7] = h;
    assign act[8] = i_o; assign act[9] = j;   assign act[10] = k;  assign act[11] = l;
    assign act[12] = m;  assign act[13] = n;  assign act[14] = o;  assign act[15] = p;

    // Reference model: mode 0 idle, 1 burst, 2 clear
    logic [8:0]  mem [16];
    logic [15:0] mvld;
    int          mode, bptr, bcount, cidx;
    logic        mdone;
    snap_t       expq [$];

    function automatic snap_t model_snap();
        snap_t s;
        for (int x = 0; x < 16; x++) s.e[x] = mem[x];
        s.v   = mvld;
        s.rdy = (mode != 2);
        s.dn  = mdone;
        return s;
    endfunction

    task automatic model_reset();
        for (int x = 0; x < 16; x++) mem[x] = '0;
        mvld = '0; mode = 0; bptr = 0; bcount = 0; cidx = 0; mdone = 1'b0;
    endtask

    task automatic model_step();
        int s;
        s = {sel3, sel2, sel1, sel0};
        mdone = 1'b0;
        if (mode == 0) begin
            if (clr) begin
                mode = 2; cidx = 0;
            end else if (burst_start) begin
                mode = 1; bptr = s; bcount = 0;
            end else if (wr) begin
                mem[s] = din; mvld[s] = 1'b1;
            end
        end else if (mode == 1) begin
            if (clr) begin
                mode = 2; cidx = 0;
            end else if (wr) begin
                mem[bptr] = din; mvld[bptr] = 1'b1;
                bptr = (bptr + 1) % 16;
                bcount++;
                if (bcount == 16) begin mode = 0; mdone = 1'b1; end
            end
        end else begin
            mem[cidx] = '0; mvld[cidx] = 1'b0;
            cidx++;
            if (cidx == 16) begin mode = 0; mdone = 1'b1; end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            if (clk) expq.push_back(model_snap());
        end else begin
            model_step();
            expq.push_back(model_snap());
        end
    end

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare(input snap_t exp, input string tag);
        for (int x = 0; x < 16; x++)
            check_val($sformatf("%s entry%0d", tag, x), {7'd0, act[x]}, {7'd0, exp.e[x]});
        check_val({tag, " VLD"}, vld, exp.v);
        check_val({tag, " ready"}, {15'd0, ready}, {15'd0, exp.rdy});
        check_val({tag, " done"}, {15'd0, done}, {15'd0, exp.dn});
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected entry at %0t", $time);
        end else begin
            compare(expq.pop_front(), "sb");
        end
    end

    task automatic cyc(input logic w, input logic [3:0] s, input logic [8:0] dv,
                       input logic bs, input logic cl);
        @(negedge clk);
        wr = w; {sel3, sel2, sel1, sel0} = s; din = dv; burst_start = bs; clr = cl;
    endtask

    task automatic idle(input int cycles);
        for (int x = 0; x < cycles; x++) cyc(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int rdy_low;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        cyc(1'b1, 4'd3, 9'h1A5, 1'b0, 1'b0);
        cyc(1'b1, 4'd15, 9'h0FF, 1'b0, 1'b0);
        idle(1);
        check_val("single D_OUT", {7'd0, d_out}, 16'h01A5);
        check_val("single P", {7'd0, p}, 16'h00FF);
        check_val("single VLD", vld, 16'h8008);

        cyc(1'b0, 4'd14, 9'd0, 1'b1, 1'b0);
        for (int x = 0; x < 16; x++) begin
            if (x == 8) cyc(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);
            cyc(1'b1, 4'(x), 9'(100 + x), 1'b0, 1'b0);
        end
        cyc(1'b1, 4'd9, 9'h1FF, 1'b0, 1'b0);
        check_val("burst done", {15'd0, done}, 16'd1);
        idle(1);
        check_val("burst O", {7'd0, o}, 16'd100);
        check_val("burst A", {7'd0, a}, 16'd102);
        check_val("burst N", {7'd0, n}, 16'd115);
        check_val("b2b J", {7'd0, j}, 16'h01FF);
        check_val("burst VLD", vld, 16'hFFFF);

        cyc(1'b1, 4'd0, 9'd0, 1'b0, 1'b1);
        rdy_low = 0;
        for (int x = 0; x < 20; x++) begin
            cyc(1'b1, 4'($urandom_range(0, 15)), 9'($urandom), 1'b0, 1'b0);
            if (!ready) rdy_low++;
        end
        check_val("clear ready low cycles", 16'(rdy_low), 16'd16);

        cyc(1'b1, 4'd5, 9'h055, 1'b1, 1'b1);
        idle(18);
        cyc(1'b0, 4'd2, 9'd0, 1'b1, 1'b0);
        for (int x = 0; x < 3; x++) cyc(1'b1, 4'd0, 9'(x + 1), 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 9'h077, 1'b0, 1'b1);
        idle(18);

        cyc(1'b0, 4'd4, 9'd0, 1'b1, 1'b0);
        for (int x = 0; x < 7; x++) cyc(1'b1, 4'd0, 9'(200 + x), 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 compare(model_snap(), "async_rst");
        check_val("async_rst VLD", vld, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 4'd0, 9'h0AB, 1'b0, 1'b0);
        idle(1);
        check_val("post_rst A", {7'd0, a}, 16'h00AB);

        for (int x = 0; x < 600; x++) begin
            cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 9'($urandom),
                $urandom_range(0, 14) == 0, $urandom_range(0, 39) == 0);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
